// File: rtl/wr_stream_arb_pkg.sv
// Shared types and width helpers for the write-stream round-robin arbiter.
package wr_stream_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_MAX_BURST = 8;
    localparam int DEF_ID_W      = id_width(DEF_N_REQ);
    localparam int DEF_CNT_W     = cnt_width(DEF_MAX_BURST);

endpackage

// File: rtl/wr_stream_arb_if.sv
// Producer-side and buffer-side stream signals of the arbiter, bundled.
interface wr_stream_arb_if #(
    parameter int DATA_WIDTH = 20,
    parameter int N_REQ      = 4
);
    logic [N_REQ*DATA_WIDTH-1:0] req_data_in;
    logic [N_REQ-1:0]            req_vld;
    logic [N_REQ-1:0]            req_rdy;
    logic [DATA_WIDTH-1:0]       data_in;
    logic                        vld;
    logic                        rdy;

    modport master (
        input  req_data_in, req_vld, rdy,
        output req_rdy, data_in, vld
    );

    modport slave (
        output req_data_in, req_vld, rdy,
        input  req_rdy, data_in, vld
    );
endinterface

// File: rtl/wr_stream_arb_rr_pick.sv
// Combinational rotate-priority finder: first set bit of req at or after ptr.
module rr_pick
    import wr_stream_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/wr_stream_arb.sv
// Round-robin burst arbiter merging N_REQ producers onto one registered write stream.
module wr_stream_arb
    import wr_stream_arb_pkg::*;
#(
    parameter int  DATA_WIDTH = 20,
    parameter int  N_REQ      = 4,
    parameter int  MAX_BURST  = 8,
    localparam int ID_W       = id_width(N_REQ)
) (
    input  logic                  clk,
    input  logic                  arst,
    wr_stream_arb_if.master       bus,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy
);

    localparam int CNT_W = cnt_width(MAX_BURST);

    arb_state_e              state;
    arb_state_e              state_nxt;
    logic [ID_W-1:0]         rr_ptr;
    logic [CNT_W-1:0]        beat_cnt;
    logic                    pick_hit;
    logic [ID_W-1:0]         pick_idx;
    logic                    grant_vld;
    logic                    out_free;
    logic                    accept;
    logic                    release_grant;
    logic [DATA_WIDTH-1:0]   grant_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req (bus.req_vld),
        .ptr (rr_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign grant_vld     = bus.req_vld[grant_id];
    assign out_free      = !bus.vld || bus.rdy;
    assign accept        = (state == GRANT) && grant_vld && out_free;
    assign release_grant = (state == GRANT) &&
                           (!grant_vld || (accept && (beat_cnt == CNT_W'(MAX_BURST - 1))));
    assign grant_data    = bus.req_data_in[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_hit)      state_nxt = GRANT;
            GRANT:   if (release_grant) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_rdy = '0;
        busy        = 1'b0;
        if (state == GRANT) begin
            busy                  = 1'b1;
            bus.req_rdy[grant_id] = out_free;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            grant_id <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            if ((state == IDLE) && pick_hit) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            // Explicit wrap keeps rr_ptr in range when N_REQ is not a power of two.
            if (release_grant)
                rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bus.vld     <= 1'b0;
            bus.data_in <= '0;
        end else if (accept) begin
            bus.vld     <= 1'b1;
            bus.data_in <= grant_data;
        end else if (bus.rdy) begin
            bus.vld     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wr_stream_arb.sv
// Directed bench for wr_stream_arb: single producer, contention, burst limit, backpressure, reset, drop.
module tb_wr_stream_arb;

    localparam int DW = 20;
    localparam int NR = 4;
    localparam int MB = 8;

    logic       clk  = 1'b0;
    logic       arst = 1'b1;
    logic [1:0] grant_id;
    logic       busy;

    wr_stream_arb_if #(.DATA_WIDTH(DW), .N_REQ(NR)) bus();

    wr_stream_arb #(
        .DATA_WIDTH (DW),
        .N_REQ      (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int              errors = 0;
    int              checks = 0;
    int              left [NR];
    int              seq  [NR];
    logic [NR-1:0]   acc;
    logic [DW-1:0]   outq [$];
    logic [DW-1:0]   expq [$];

    function automatic logic [DW-1:0] d(input int i, input int s);
        return {4'(i), 16'(s)};
    endfunction

    // Beats transferred to the buffer are taken at the edge following this sample.
    always @(negedge clk) begin
        if (!arst && bus.vld && bus.rdy) outq.push_back(bus.data_in);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_vld[i]              = (left[i] > 0);
            bus.req_data_in[i*DW +: DW] = d(i, seq[i]);
        end
    endtask

    task automatic load(input int i, input int n);
        left[i] = n;
        seq[i]  = 0;
        drive();
    endtask

    // One cycle: note accepts, cross the edge, advance producers, let comb settle.
    task automatic tick();
        @(negedge clk);
        acc = bus.req_vld & bus.req_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                seq[i]++;
                left[i]--;
            end
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        arst    = 1'b1;
        bus.rdy = 1'b1;
        acc     = '0;
        for (int i = 0; i < NR; i++) begin
            left[i] = 0;
            seq[i]  = 0;
        end
        drive();
        tick();
        tick();
        arst = 1'b0;
        outq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_vld", 32'(bus.vld), 0);
        check("rst_data", 32'(bus.data_in), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_rdy", 32'(bus.req_rdy), 0);
        check("rst_grant_id", 32'(grant_id), 0);

        // Single producer: three beats A, B, C
        load(0, 3);
        #1;
        check("t1_idle_req_rdy", 32'(bus.req_rdy), 0);
        check("t1_idle_busy", 32'(busy), 0);
        tick();
        check("t1_c1_busy", 32'(busy), 1);
        check("t1_c1_grant", 32'(grant_id), 0);
        check("t1_c1_req_rdy", 32'(bus.req_rdy), 32'b0001);
        check("t1_c1_vld", 32'(bus.vld), 0);
        tick();
        check("t1_c2_vld", 32'(bus.vld), 1);
        check("t1_c2_data", 32'(bus.data_in), 32'(d(0, 0)));
        tick();
        check("t1_c3_data", 32'(bus.data_in), 32'(d(0, 1)));
        tick();
        check("t1_c4_vld", 32'(bus.vld), 1);
        check("t1_c4_data", 32'(bus.data_in), 32'(d(0, 2)));
        check("t1_c4_busy", 32'(busy), 1);
        tick();
        check("t1_c5_vld", 32'(bus.vld), 0);
        check("t1_c5_busy", 32'(busy), 0);
        check("t1_c5_grant", 32'(grant_id), 0);
        check("t1_count", 32'(outq.size()), 3);

        // Contention: producers 1 and 3, two beats each
        do_reset();
        load(1, 2);
        load(3, 2);
        tick();
        check("t2_c1_grant", 32'(grant_id), 1);
        check("t2_c1_req_rdy", 32'(bus.req_rdy), 32'b0010);
        tick();
        check("t2_c2_data", 32'(bus.data_in), 32'(d(1, 0)));
        tick();
        check("t2_c3_data", 32'(bus.data_in), 32'(d(1, 1)));
        tick();
        check("t2_c4_busy", 32'(busy), 0);
        check("t2_c4_vld", 32'(bus.vld), 0);
        tick();
        check("t2_c5_grant", 32'(grant_id), 3);
        check("t2_c5_req_rdy", 32'(bus.req_rdy), 32'b1000);
        tick();
        check("t2_c6_data", 32'(bus.data_in), 32'(d(3, 0)));
        tick();
        check("t2_c7_data", 32'(bus.data_in), 32'(d(3, 1)));
        tick();
        check("t2_c8_vld", 32'(bus.vld), 0);
        check("t2_c8_rr_ptr", 32'(dut.rr_ptr), 0);

        // Burst limit: producer 2 streams 20 beats, producer 0 joins with 2
        do_reset();
        load(2, 20);
        tick();
        load(0, 2);
        repeat (8) tick();
        check("t3_c9_busy", 32'(busy), 0);
        check("t3_c9_rr_ptr", 32'(dut.rr_ptr), 3);
        tick();
        check("t3_c10_grant", 32'(grant_id), 0);
        for (int n = 0; n < 60 && outq.size() < 22; n++) tick();
        expq.delete();
        for (int s = 0; s < 8; s++)  expq.push_back(d(2, s));
        expq.push_back(d(0, 0));
        expq.push_back(d(0, 1));
        for (int s = 8; s < 20; s++) expq.push_back(d(2, s));
        check("t3_count", 32'(outq.size()), 22);
        for (int k = 0; k < 22 && k < outq.size(); k++)
            check($sformatf("t3_beat%0d", k), 32'(outq[k]), 32'(expq[k]));

        // Backpressure: rdy low for four cycles mid-burst
        do_reset();
        load(1, 6);
        repeat (3) tick();
        bus.rdy = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            check($sformatf("t4_hold_data%0d", c), 32'(bus.data_in), 32'(d(1, 1)));
            check($sformatf("t4_hold_vld%0d", c), 32'(bus.vld), 1);
            check($sformatf("t4_hold_req_rdy%0d", c), 32'(bus.req_rdy), 0);
        end
        tick();
        bus.rdy = 1'b1;
        #1;
        check("t4_resume_req_rdy", 32'(bus.req_rdy), 32'b0010);
        for (int n = 0; n < 30 && outq.size() < 6; n++) tick();
        check("t4_count", 32'(outq.size()), 6);
        for (int k = 0; k < 6 && k < outq.size(); k++)
            check($sformatf("t4_beat%0d", k), 32'(outq[k]), 32'(d(1, k)));

        // Reset mid-burst at the third beat
        do_reset();
        load(2, 8);
        repeat (4) tick();
        check("t5_pre_data", 32'(bus.data_in), 32'(d(2, 2)));
        arst = 1'b1;
        #1;
        check("t5_rst_vld", 32'(bus.vld), 0);
        check("t5_rst_req_rdy", 32'(bus.req_rdy), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_data", 32'(bus.data_in), 0);
        load(1, 2);
        tick();
        arst = 1'b0;
        tick();
        check("t5_regrant", 32'(grant_id), 1);
        check("t5_regrant_busy", 32'(busy), 1);
        check("t5_count", 32'(outq.size()), 2);

        // Producer drop after one beat
        do_reset();
        load(0, 1);
        load(3, 1);
        tick();
        check("t6_c1_grant", 32'(grant_id), 0);
        tick();
        check("t6_c2_busy", 32'(busy), 1);
        check("t6_c2_data", 32'(bus.data_in), 32'(d(0, 0)));
        tick();
        check("t6_c3_busy", 32'(busy), 0);
        tick();
        check("t6_c4_grant", 32'(grant_id), 3);
        check("t6_c4_req_rdy", 32'(bus.req_rdy), 32'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wr_stream_arb.md
# wr_stream_arb

Round-robin arbiter that shares the elastic buffer's single write stream (`data_in`/`vld`/`rdy`) among `N_REQ` independent producers. A grant is held for a burst of up to `MAX_BURST` beats, or until the granted producer drops `vld`. Merged beats leave through a one-entry output register. The block sits directly in front of the buffer's write port, and its output side connects to a `wr_stream_if` `tb`-style master.

## Interface
- `DATA_WIDTH`, 20: beat width; matches the buffer write port.
- `N_REQ`, 4: number of producers, at least 2.
- `MAX_BURST`, 8: maximum beats accepted per grant, at least 1.
- `clk`  in  1: single clock.
- `arst`  in  1: reset; asynchronous, active-high.
- `req_data_in`  in  `N_REQ*DATA_WIDTH`: producer beats, packed; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_vld`  in  `N_REQ`: producer valid.
- `req_rdy`  out  `N_REQ`: producer ready; at most one bit high.
- `data_in`  out  `DATA_WIDTH`: merged beat to the buffer; registered.
- `vld`  out  1: merged valid; registered.
- `rdy`  in  1: buffer ready.
- `grant_id`  out  `$clog2(N_REQ)`: current or last granted producer; registered.
- `busy`  out  1: high in GRANT state.

## Operation
- **States:**
  - IDLE: arbitrate.
  - GRANT: stream from `grant_id`.
- **IDLE:**
  - Search `req_vld` round-robin, starting at index `rr_ptr`.
  - On a hit: register `grant_id`, clear `beat_cnt`, go to GRANT.
  - `req_rdy` is all-zero in IDLE.
- **GRANT:**
  - `req_rdy[grant_id] = !vld || rdy`; all other bits are 0. This path is combinational from `rdy`.
  - An accept is `req_vld[grant_id] && req_rdy[grant_id]`.
  - On accept: the output register loads the beat, `vld` is set, and `beat_cnt` increments.
- **Output register:**
  - `vld` clears when `rdy` is high and no new beat is accepted.
  - `data_in` and `vld` hold while `vld && !rdy`.
- **Release:** leave GRANT for IDLE when either condition holds:
  - An accept brings `beat_cnt` to `MAX_BURST`.
  - `req_vld[grant_id]` is low in any GRANT cycle.
- **On release:** `rr_ptr` is set to `grant_id+1`, wrapping modulo `N_REQ`.
- **Ordering:**
  - No beat is ever dropped or duplicated.
  - Beats from one grant appear in order and contiguous on the output.
- **Reset** (asynchronous, any state, including mid-burst):
  - State = IDLE.
  - `rr_ptr`, `beat_cnt`, `grant_id` = 0.
  - `vld` = 0, `data_in` = 0, `busy` = 0.
  - `req_rdy` = 0.
  - A beat held in the output register at reset is discarded.
- **Widths:**
  - `beat_cnt` is `$clog2(MAX_BURST+1)` bits.
  - `rr_ptr` wraps explicitly for non-power-of-2 `N_REQ`.

## Timing
- **Arbitration:** producer raises `vld` in cycle 0 while in IDLE → grant registered at the end of cycle 0 → `req_rdy` high in cycle 1 → beat appears on `data_in`/`vld` in cycle 2.
- **Throughput:** one beat per cycle inside a grant while `rdy` is high.
- **Grant overhead:** exactly one idle cycle (re-arbitration) between consecutive grants.
- **Backpressure:** `rdy` low with `vld` high forces `req_rdy` low in that same cycle.
- **Release and re-request:** a producer released by the burst limit can win again only after every other requesting producer has been served once.

## Structure
- **Package** `wr_stream_arb_pkg`:
  - State enum `arb_state_e` {IDLE, GRANT}.
  - Width helper localparams for the `grant_id` and `beat_cnt` widths.
- **Sub-module** `rr_pick`:
  - Purely combinational rotate-priority finder.
  - Inputs: `req[N_REQ]`, `ptr`.
  - Outputs: `hit`, `idx`.
- **Top module:** FSM, burst counter and output register.

## Test plan
- **Single producer:** producer 0 sends 3 beats A, B, C with `rdy`=1 → `vld` high in cycles 2–4 carrying A, B, C; release when `vld` drops; `grant_id`=0.
- **Contention:** producers 1 and 3 each send 2 beats from reset → 1's beats, one idle cycle, then 3's beats; `rr_ptr`=0 after the second release (3+1 wraps to 0).
- **Burst limit:** producer 2 holds `vld` for 20 beats while producer 0 also requests, `MAX_BURST`=8 → 8 beats from 2, then 0 served, then 2 resumes at beat 9.
- **Backpressure:** `rdy` low for 4 cycles mid-burst → `data_in`/`vld` stable, `req_rdy` low; no loss or duplication when `rdy` returns.
- **Reset mid-burst:** `arst` pulse at beat 3 of 8 → `vld`, `req_rdy`, `busy` = 0 immediately; next grant goes to the lowest requesting index starting from 0.
- **Producer drop:** granted producer lowers `vld` after 1 beat → release, and the next requester is granted two cycles later.
